// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the writeback trace buffer.
package wb_trace_pkg;

  localparam int TRACE_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } trace_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } trace_state_t;

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace FIFO storage with a registered head entry. Occupancy is tracked
// by an explicit counter; the head register is loaded with the entry that
// will sit at the read pointer after the current edge, so the outputs are
// registered yet an entry pushed into an empty FIFO is visible one cycle later.
module trace_fifo_mem
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_req,
  input  logic                     pop_req,
  input  trace_entry_t             wr_entry,
  output trace_entry_t             head,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     accept,
  output logic                     drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  trace_entry_t           mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       rd_ptr_nxt;
  logic [CW-1:0]          count_nxt;
  trace_entry_t           head_nxt;
  logic                   full;
  logic                   pop;

  assign full   = (count == CW'(DEPTH));
  assign pop    = head_valid & pop_req;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign accept = push_req & (~full | pop);
  assign drop   = push_req & full & ~pop;

  assign rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

  // Next occupancy and next head entry (bypass when the push lands at the head).
  always_comb begin
    count_nxt = count;
    if (accept && !pop)      count_nxt = count + CW'(1);
    else if (!accept && pop) count_nxt = count - CW'(1);
    if (accept && (wr_ptr == rd_ptr_nxt)) head_nxt = wr_entry;
    else                                  head_nxt = mem[rd_ptr_nxt];
  end

  // Entry storage; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_entry;
  end

  // Pointers, occupancy and registered head; head holds while nothing is queued.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
      if (count_nxt != '0) head <= head_nxt;
    end
  end

endmodule

// File: rtl/wb_trace_fifo.sv
// Writeback trace buffer top: capture FSM, overflow statistics and optional
// duplicate suppression around the trace FIFO.
// Optional feature macro: WB_TRACE_DEDUP_EN (suppress pushes identical to
// the last accepted entry).
module wb_trace_fifo
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [31:0]            PCVal,
  input  logic [31:0]            WriteDataOut,
  input  logic                   WbValid,
  input  logic                   En,
  input  logic                   ClrStat,
  output logic                   TraceValid,
  input  logic                   TraceReady,
  output logic [31:0]            TracePC,
  output logic [31:0]            TraceData,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow,
  output logic [CNT_W-1:0]       DropCount,
  output logic [1:0]             State
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  trace_entry_t cur;
  trace_entry_t head;
  logic         dup;
  logic         push_req;
  logic         accept;
  logic         drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign cur      = {PCVal, WriteDataOut};
  assign push_req = (state == S_RUN) & WbValid & ~dup;

`ifdef WB_TRACE_DEDUP_EN
  logic         last_vld;
  trace_entry_t last_entry;

  assign dup = last_vld & (last_entry == cur);

  // Remember the last accepted entry; forgotten on a fresh capture session.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      last_vld   <= 1'b0;
      last_entry <= '0;
    end else if (state == S_IDLE && state_nxt == S_RUN) begin
      last_vld   <= 1'b0;
    end else if (accept) begin
      last_vld   <= 1'b1;
      last_entry <= cur;
    end
  end
`else
  assign dup = 1'b0;
`endif

  trace_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk        (Clk),
    .reset_n    (Reset_n),
    .push_req   (push_req),
    .pop_req    (TraceReady),
    .wr_entry   (cur),
    .head       (head),
    .head_valid (TraceValid),
    .count      (Count),
    .accept     (accept),
    .drop       (drop)
  );

  assign TracePC   = head.pc;
  assign TraceData = head.data;
  assign State     = state;

  // Capture FSM next-state; re-enabling wins over finishing a drain.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (En) state_nxt = S_RUN;
      S_RUN:   if (!En) state_nxt = (Count != '0) ? S_DRAIN : S_IDLE;
      S_DRAIN: begin
        if (En)                                          state_nxt = S_RUN;
        else if (TraceValid && TraceReady && Count == 1) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Sticky overflow flag and saturating drop counter; clear beats a drop.
  always_ff @(posedge Clk) begin
    if (!Reset_n || ClrStat) begin
      Overflow  <= 1'b0;
      DropCount <= '0;
    end else if (drop) begin
      Overflow  <= 1'b1;
      DropCount <= sat_inc(DropCount);
    end
  end

endmodule
